// File: rtl/div_stall_unit_pkg.sv
// Shared definitions for the EX-stage divider: stall bus layout, stall levels,
// FSM encodings and default width.
package div_stall_unit_pkg;

    localparam int unsigned StallBusW = 6;
    localparam int unsigned DivWidth  = 32;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Controller response when EX is the stall source: PC, IF, ID and EX held.
    localparam logic [StallBusW-1:0] StallByEx = 6'b001111;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_ZERO = 2'b01;
    localparam logic [1:0] DIV_ON   = 2'b10;
    localparam logic [1:0] DIV_END  = 2'b11;

endpackage

// File: rtl/div_stall_unit_iter_step.sv
// One combinational restoring-division step: shift {rem,dq} left by one,
// trial-subtract the divisor and shift the resulting quotient bit into dq.
module div_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    always_comb begin
        shifted = {rem_i, dq_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        q_bit   = ~diff[WIDTH];
        rem_o   = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dq_o    = {dq_i[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/div_stall_unit.sv
// Multi-cycle DIV/DIVU unit in EX that raises the EX stall request while busy.
// Optional macro DIV_FAST_ZERO_EN: short-cut path for a zero divisor.
module div_stall_unit
    import div_stall_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 annul,
    input  logic [StallBusW-1:0] stall,
    output logic                 stallreq_for_ex,
    output logic                 ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;

    logic [WIDTH-1:0] step_rem, step_dq;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             ex_free, start_ok;

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem_q),
        .dq_i     (dq_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .dq_o     (step_dq)
    );

    assign a_mag = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // EX is free unless a later stage holds it; a bare EX stall is taken as our own,
    // which keeps the request independent of the stall bus (no combinational loop).
    assign ex_free  = ~stall[3] | (stall == StallByEx);
    assign start_ok = start & ~annul & ex_free;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;

        case (state_q)
            DIV_IDLE: begin
                if (start_ok) begin
                    rem_d   = '0;
                    dq_d    = a_mag;
                    dvs_d   = b_mag;
                    qsign_d = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) & signed_op;
                    rsign_d = op_a[WIDTH-1] & signed_op;
                    cnt_d   = '0;
`ifdef DIV_FAST_ZERO_EN
                    state_d = (op_b == '0) ? DIV_ZERO : DIV_ON;
`else
                    state_d = DIV_ON;
`endif
                end
            end
            DIV_ON: begin
                rem_d = step_rem;
                dq_d  = step_dq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_END;
                    quo_d   = qsign_q ? -step_dq : step_dq;
                    remo_d  = rsign_q ? -step_rem : step_rem;
                end
            end
`ifdef DIV_FAST_ZERO_EN
            DIV_ZERO: begin
                state_d = DIV_END;
                quo_d   = qsign_q ? -{WIDTH{1'b1}} : {WIDTH{1'b1}};
                remo_d  = rsign_q ? -dq_q : dq_q;
            end
`endif
            DIV_END: state_d = DIV_IDLE;
            default: state_d = DIV_IDLE;
        endcase

        if (annul) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
            quo_d   = quo_q;
            remo_d  = remo_q;
        end
    end

    always_comb begin
        stallreq_for_ex = NoStop;
        if (rst && !annul) begin
            case (state_q)
                DIV_IDLE: stallreq_for_ex = start ? Stop : NoStop;
                DIV_ON:   stallreq_for_ex = Stop;
`ifdef DIV_FAST_ZERO_EN
                DIV_ZERO: stallreq_for_ex = Stop;
`endif
                default:  stallreq_for_ex = NoStop;
            endcase
        end
        ready = rst & ~annul & (state_q == DIV_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// Self-checking bench for div_stall_unit: directed cases with literal expectations
// plus randomized traffic checked every cycle against a cycle-count/arithmetic model.
module tb_div_stall_unit;

`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, signed_op, annul;
    logic [31:0] op_a, op_b;
    logic [5:0]  ext_stall;
    logic [5:0]  stall;
    logic        stallreq_for_ex, ready;
    logic [31:0] quotient, remainder;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Controller model: answers our request with 001111, merged with other sources.
    assign stall = ext_stall | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    div_stall_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .signed_op      (signed_op),
        .op_a           (op_a),
        .op_b           (op_b),
        .annul          (annul),
        .stall          (stall),
        .stallreq_for_ex(stallreq_for_ex),
        .ready          (ready),
        .quotient       (quotient),
        .remainder      (remainder)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_busy = 0;   // stall cycles still to run before the result cycle
    bit          m_done = 0;   // current cycle is the result cycle
    logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

    task automatic compute(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] am, bm, qm, rm;
        bit qs, rs;
        am = (s && a[31]) ? -a : a;
        bm = (s && b[31]) ? -b : b;
        qm = (bm == 0) ? 32'hFFFF_FFFF : am / bm;
        rm = (bm == 0) ? am : am % bm;
        qs = s && (a[31] ^ b[31]);
        rs = s && a[31];
        p_q = qs ? -qm : qm;
        p_r = rs ? -rm : rm;
    endtask

    always @(negedge clk) begin
        logic es, er;
        logic [5:0] st;
        if (!rst) begin
            m_busy = 0; m_done = 0; m_q = '0; m_r = '0;
            chk("m_rst_stallreq", {31'b0, stallreq_for_ex}, 32'd0);
            chk("m_rst_ready", {31'b0, ready}, 32'd0);
            chk("m_rst_quotient", quotient, 32'd0);
            chk("m_rst_remainder", remainder, 32'd0);
        end else begin
            if (m_busy > 0)  begin es = !annul; er = 1'b0; end
            else if (m_done) begin es = 1'b0;   er = !annul; end
            else             begin es = start && !annul; er = 1'b0; end
            chk("m_stallreq", {31'b0, stallreq_for_ex}, {31'b0, es});
            chk("m_ready", {31'b0, ready}, {31'b0, er});
            chk("m_quotient", quotient, m_q);
            chk("m_remainder", remainder, m_r);
            st = ext_stall | (es ? 6'b001111 : 6'b000000);
            if (m_busy > 0) begin
                if (annul) m_busy = 0;
                else begin
                    m_busy--;
                    if (m_busy == 0) begin m_done = 1; m_q = p_q; m_r = p_r; end
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (start && !annul && (!st[3] || st == 6'b001111)) begin
                compute(signed_op, op_a, op_b);
                m_busy = (FAST && op_b == 0) ? 1 : 32;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nst, output logic [31:0] q, output logic [31:0] r);
        @(posedge clk); #1;
        start = 1'b1; signed_op = s; op_a = a; op_b = b; ext_stall = '0;
        lat = -1; nst = 0; q = '0; r = '0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (stallreq_for_ex) nst++;
            if (ready) begin lat = c; q = quotient; r = remainder; break; end
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return $urandom_range(1, 20);
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nst, nrdy;
        logic [31:0] q, r, hq, hr;
        logic [31:0] zl;

        rst = 1'b0; start = 1'b1; signed_op = 1'b0; annul = 1'b0;
        op_a = 32'd5; op_b = 32'd1; ext_stall = '0;
        #3;
        chk("rst_stallreq_start_high", {31'b0, stallreq_for_ex}, 32'd0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("idle_quotient", quotient, 32'd0);

        // DIVU 100/7
        do_op(1'b0, 32'd100, 32'd7, lat, nst, q, r);
        chk("divu100_7_lat", lat, 32'd33);
        chk("divu100_7_stallcycles", nst, 32'd33);
        chk("divu100_7_q", q, 32'd14);
        chk("divu100_7_r", r, 32'd2);
        chk("divu100_7_end_stall", {31'b0, stallreq_for_ex}, 32'd0);
        chk("model_q_pin", m_q, 32'd14);
        go_idle();
        @(negedge clk);
        chk("divu100_7_ready_one_cycle", {31'b0, ready}, 32'd0);

        // DIV -100/7
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, nst, q, r);
        chk("div_m100_7_lat", lat, 32'd33);
        chk("div_m100_7_q", q, 32'hFFFF_FFF2);
        chk("div_m100_7_r", r, 32'hFFFF_FFFE);
        chk("model_r_pin", m_r, 32'hFFFF_FFFE);
        go_idle();
        @(negedge clk);
        chk("div_m100_7_ready_one_cycle", {31'b0, ready}, 32'd0);

        // DIVU by zero
        zl = FAST ? 32'd2 : 32'd33;
        do_op(1'b0, 32'h1234_5678, 32'd0, lat, nst, q, r);
        chk("divzero_lat", lat, zl);
        chk("divzero_stallcycles", nst, zl);
        chk("divzero_q", q, 32'hFFFF_FFFF);
        chk("divzero_r", r, 32'h1234_5678);
        go_idle();
        hq = 32'hFFFF_FFFF; hr = 32'h1234_5678;

        // annul at cycle 10 of DIVU 50/5
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; op_a = 32'd50; op_b = 32'd5;
        for (int c = 0; c < 10; c++) @(negedge clk);
        @(posedge clk); #1 annul = 1'b1;
        @(negedge clk);
        chk("annul_stallreq_same_cycle", {31'b0, stallreq_for_ex}, 32'd0);
        @(posedge clk); #1 annul = 1'b0; start = 1'b0;
        nrdy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ready) nrdy++;
        end
        chk("annul_no_ready", nrdy, 32'd0);
        chk("annul_q_held", quotient, hq);
        chk("annul_r_held", remainder, hr);

        // back-to-back
        do_op(1'b0, 32'd9, 32'd2, lat, nst, q, r);
        chk("b2b_first_lat", lat, 32'd33);
        chk("b2b_first_q", q, 32'd4);
        chk("b2b_first_r", r, 32'd1);
        do_op(1'b0, 32'd20, 32'd3, lat, nst, q, r);
        chk("b2b_second_lat", lat, 32'd33);
        chk("b2b_second_q", q, 32'd6);
        chk("b2b_second_r", r, 32'd2);
        go_idle();

        // later-stage stall blocks acceptance
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; op_a = 32'd77; op_b = 32'd10; ext_stall = 6'b011111;
        for (int c = 0; c < 3; c++) @(negedge clk);
        do_op(1'b0, 32'd77, 32'd10, lat, nst, q, r);
        chk("blocked_then_lat", lat, 32'd33);
        chk("blocked_then_q", q, 32'd7);
        chk("blocked_then_r", r, 32'd7);
        go_idle();

        // async reset mid-ON
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b1; op_a = 32'd1000; op_b = 32'd3;
        for (int c = 0; c < 12; c++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_stallreq", {31'b0, stallreq_for_ex}, 32'd0);
        chk("midrst_ready", {31'b0, ready}, 32'd0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, nst, q, r);
        chk("minint_lat", lat, 32'd33);
        chk("minint_q", q, 32'h8000_0000);
        chk("minint_r", r, 32'd0);
        go_idle();

        // randomized traffic; the model process checks every cycle
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(posedge clk); #1;
            annul = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 7))
                0: ext_stall = 6'b011111;
                1: ext_stall = 6'b000111;
                default: ext_stall = 6'b000000;
            endcase
            if (!stallreq_for_ex) begin
                start     = $urandom_range(0, 2) != 0;
                signed_op = $urandom_range(0, 1);
                op_a      = rnd_word();
                op_b      = rnd_word();
            end
        end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0; ext_stall = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Multi-cycle 32-bit divider in the EX stage.
- Initiates the EX stall request toward the pipeline controller and holds EX until the quotient and remainder are ready.
- Consumes the controller's stall bus only to detect when it is itself the stall source.
- Serves DIV/DIVU. Results go to the HI/LO write path: remainder to HI, quotient to LO.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  EX holds a DIV/DIVU; held high for as long as EX is stalled
- signed_op  in  1  1 = DIV, 0 = DIVU
- op_a  in  WIDTH  dividend
- op_b  in  WIDTH  divisor
- annul  in  1  flush of EX; aborts any operation
- stall  in  6  controller stall bus (bit0 PC … bit5 WB); informational only
- stallreq_for_ex  out  1  stall request to controller (expected response 6'b001111)
- ready  out  1  one-cycle pulse; result valid
- quotient  out  WIDTH  LO value
- remainder  out  WIDTH  HI value

Behaviour:
- States: IDLE, DIVZERO, ON, END.
- Reset (rst=0, async): state=IDLE, counter=0, quotient=0, remainder=0, ready=0, stallreq_for_ex=0.
- IDLE:
  - start=1 and annul=0: latch |op_a| and |op_b| (two's-complement abs if signed_op), the quotient sign (a[31]^b[31])&signed_op, and the remainder sign a[31]&signed_op.
  - Go to DIVZERO if op_b==0, else to ON with counter=0.
- ON: one restoring iteration per cycle:
  - shift {rem,dividend} left 1; trial subtract divisor; commit if non-negative; shift quotient bit in.
  - counter increments; after the iteration with counter==WIDTH-1, go to END.
- DIVZERO: one cycle. Load quotient=all ones, remainder=dividend (pre-sign-fix magnitudes). Go to END.
- END:
  - ready=1; outputs show sign-corrected results (negate quotient if its sign is set; negate remainder if its sign is set).
  - Next state is IDLE unconditionally.
- stallreq_for_ex is combinational: 1 when (IDLE & start & ~annul) | ON | DIVZERO; 0 in END.
- Latency for a nonzero divisor:
  - start seen in cycle 0 (stall high); ON occupies cycles 1..32; END in cycle 33 with ready=1 and stall low.
  - Total stall: 33 cycles. EX advances on the edge ending cycle 33.
- Back-to-back: a new start in the IDLE cycle after END begins a new operation; no dead cycle is required beyond END.
- annul=1 in any state: next state IDLE, counter cleared, no ready pulse, stallreq_for_ex forced 0 in the same cycle.
- Results hold their value after END until the next END. ready is 1 only in END.
- Reset mid-operation: immediate IDLE, all outputs 0.
- Signed corner case: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- If stall[3]=1 while the unit is idle, the unit does not start a new operation. start is honoured only when the controller is not stalling EX for another source, or the stall is this unit's own.

Optional Feature:
- DIV_FAST_ZERO_EN
- Defined: divisor==0 takes the DIVZERO path; the result arrives in cycle 2, with stall high in cycles 0–1.
- Undefined: the DIVZERO state is not compiled in; divide-by-zero runs the full 32 ON iterations.
  - The restoring algorithm naturally yields quotient=all ones and remainder=dividend.
  - Sign correction and END timing are identical to the normal case.
- Result values are identical either way; only latency differs.

Decomposition:
- Shared defines: StallBus width, Stop/NoStop, state encodings DIV_IDLE/DIV_ZERO/DIV_ON/DIV_END, WIDTH default.
- One natural sub-module: div_iter_step, the combinational single restoring step: {rem,dq} in, divisor in → {rem,dq} out.
- FSM, counter, and sign fix-up stay in the top module.

Test Plan:
- DIVU 100/7, start held → stall high for cycles 0..32; cycle 33: ready=1, quotient=14, remainder=2, stall=0.
- DIV -100/7 (0xFFFFFF9C / 7) → quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2), ready exactly one cycle.
- DIVU 0x12345678/0:
  - with DIV_FAST_ZERO_EN: ready in cycle 2, quotient=0xFFFFFFFF, remainder=0x12345678.
  - without: same values at cycle 33.
- annul pulsed at cycle 10 of DIVU 50/5 → stallreq_for_ex=0 in cycle 10, IDLE at cycle 11, no ready pulse, quotient/remainder unchanged.
- Back-to-back: DIVU 9/2 then DIVU 20/3 with start re-asserted in the cycle after END → results 4 r1, then 6 r2 at cycles 33 and 67.
- rst=0 asserted asynchronously mid-ON → outputs 0 without waiting for clk; after rst=1, a fresh DIV 0x80000000/0xFFFFFFFF gives quotient=0x80000000, remainder=0.
